// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared flit layout, response codes and FSM states for the mesh write endpoint
package mesh_pkg;

  localparam int FLIT_W  = 40;
  localparam int COORD_W = 4;

  typedef enum logic [1:0] {
    FLIT_WREQ = 2'b01,
    FLIT_BRSP = 2'b11
  } flit_type_e;

  // header field low-bit positions
  localparam int TYPE_LO = 38;
  localparam int DSTX_LO = 34;
  localparam int DSTY_LO = 30;
  localparam int SRCX_LO = 26;
  localparam int SRCY_LO = 22;
  localparam int ID_LO   = 18;
  localparam int LEN_LO  = 10;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_ADDR,
    ST_AW,
    ST_DATA,
    ST_BWAIT,
    ST_RESP,
    ST_DROP
  } wr_state_e;

endpackage

// File: rtl/wr_beat_ctrl.sv
// rtl/wr_beat_ctrl.sv - W-channel beat counter with wlast, short-packet padding and overlong-packet detection
module wr_beat_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic [7:0] len,
  input  logic       flit_valid,
  input  logic       flit_last,
  input  logic       wready,
  output logic       wvalid,
  output logic       flit_ready,
  output logic       wlast,
  output logic       pad,
  output logic       burst_done,
  output logic       early_last,
  output logic       extra_flit
);

  logic [7:0] cnt;
  logic       pad_q;
  logic       beat;

  // once padding starts the flit stream is no longer consulted for this burst
  assign pad        = pad_q;
  assign wlast      = active && (cnt == len);
  assign wvalid     = active && (pad_q || flit_valid);
  assign flit_ready = active && !pad_q && wready;
  assign beat       = wvalid && wready;
  assign burst_done = beat && wlast;
  assign early_last = beat && !pad_q && flit_last && !wlast;
  assign extra_flit = burst_done && !pad_q && !flit_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 8'd0;
      pad_q <= 1'b0;
    end else if (!active) begin
      cnt   <= 8'd0;
      pad_q <= 1'b0;
    end else if (beat) begin
      if (wlast) begin
        cnt   <= 8'd0;
        pad_q <= 1'b0;
      end else begin
        cnt <= cnt + 8'd1;
        if (early_last) pad_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_axi_wr_endpoint.sv
// rtl/mesh_axi_wr_endpoint.sv - replays mesh write-request packets as AXI4 bursts and returns a BRSP flit
// Optional counters stat_done/stat_err are built when MESH_AXI_WR_STATS_EN is defined.
module mesh_axi_wr_endpoint
  import mesh_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ROUTER_X   = 0,
  parameter int ROUTER_Y   = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [39:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [39:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [ID_WIDTH-1:0]   awid,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_WIDTH-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
`ifdef MESH_AXI_WR_STATS_EN
  ,
  output logic [15:0]           stat_done,
  output logic [15:0]           stat_err
`endif
);

  localparam logic [COORD_W-1:0] OWN_X = COORD_W'(ROUTER_X);
  localparam logic [COORD_W-1:0] OWN_Y = COORD_W'(ROUTER_Y);

  wr_state_e state, state_n;

  logic                  live;
  logic [COORD_W-1:0]    src_x_q, src_y_q, id_q;
  logic [7:0]            len_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  err_q, drop_to_bwait;
  logic [1:0]            bresp_q;

  logic       in_data, flit_ready, pad, burst_done, early_last, extra_flit;
  logic [1:0] hdr_type;
  logic       is_wreq;
  logic [39:0] rsp_flit;
  logic       unused_ok;

  assign hdr_type  = s_axis_tdata[TYPE_LO +: 2];
  assign is_wreq   = (hdr_type == FLIT_WREQ);
  assign in_data   = (state == ST_DATA);
  assign unused_ok = ^{bid, s_axis_tdata[DSTX_LO +: 2*COORD_W]};

  wr_beat_ctrl u_beat (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .active     (in_data),
    .len        (len_q),
    .flit_valid (s_axis_tvalid),
    .flit_last  (s_axis_tlast),
    .wready     (wready),
    .wvalid     (wvalid),
    .flit_ready (flit_ready),
    .wlast      (wlast),
    .pad        (pad),
    .burst_done (burst_done),
    .early_last (early_last),
    .extra_flit (extra_flit)
  );

  assign awaddr  = addr_q;
  assign awid    = ID_WIDTH'(id_q);
  assign awlen   = len_q;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wdata   = (in_data && !pad) ? s_axis_tdata[DATA_WIDTH-1:0] : '0;
  assign wstrb   = (in_data && !pad) ? s_axis_tdata[35:32] : 4'h0;

  assign rsp_flit     = {FLIT_BRSP, src_x_q, src_y_q, OWN_X, OWN_Y, id_q, 16'h0000, bresp_q};
  assign m_axis_tdata = m_axis_tvalid ? rsp_flit : 40'h0;
  assign m_axis_tlast = m_axis_tvalid;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ST_HDR;
      live  <= 1'b0;
    end else begin
      state <= state_n;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_n       = state;
    s_axis_tready = 1'b0;
    awvalid       = 1'b0;
    bready        = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state)
      ST_HDR: begin
        s_axis_tready = live;
        if (live && s_axis_tvalid) begin
          if (!is_wreq)          state_n = s_axis_tlast ? ST_HDR : ST_DROP;
          else if (s_axis_tlast) state_n = ST_RESP;
          else                   state_n = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_n = s_axis_tlast ? ST_RESP : ST_AW;
      end
      ST_AW: begin
        awvalid = 1'b1;
        if (awready) state_n = ST_DATA;
      end
      ST_DATA: begin
        s_axis_tready = flit_ready;
        if (burst_done) state_n = extra_flit ? ST_DROP : ST_BWAIT;
      end
      ST_BWAIT: begin
        bready = 1'b1;
        if (bvalid) state_n = ST_RESP;
      end
      ST_RESP: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_n = ST_HDR;
      end
      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_n = drop_to_bwait ? ST_BWAIT : ST_HDR;
      end
      default: state_n = ST_HDR;
    endcase
  end

  // a request header that is also the last flit is answered with SLVERR and no AXI traffic
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      src_x_q       <= '0;
      src_y_q       <= '0;
      id_q          <= '0;
      len_q         <= '0;
      addr_q        <= '0;
      err_q         <= 1'b0;
      drop_to_bwait <= 1'b0;
      bresp_q       <= BRESP_OKAY;
    end else begin
      case (state)
        ST_HDR: if (live && s_axis_tvalid) begin
          src_x_q       <= s_axis_tdata[SRCX_LO +: COORD_W];
          src_y_q       <= s_axis_tdata[SRCY_LO +: COORD_W];
          id_q          <= s_axis_tdata[ID_LO +: COORD_W];
          len_q         <= s_axis_tdata[LEN_LO +: 8];
          err_q         <= 1'b0;
          drop_to_bwait <= 1'b0;
          bresp_q       <= (is_wreq && s_axis_tlast) ? BRESP_SLVERR : BRESP_OKAY;
        end
        ST_ADDR: if (s_axis_tvalid) begin
          addr_q <= s_axis_tdata[ADDR_WIDTH-1:0];
          if (s_axis_tlast) bresp_q <= BRESP_SLVERR;
        end
        ST_DATA: begin
          if (early_last || extra_flit) err_q <= 1'b1;
          if (extra_flit) drop_to_bwait <= 1'b1;
        end
        ST_BWAIT: if (bvalid) begin
          bresp_q <= (err_q && bresp != BRESP_DECERR) ? BRESP_SLVERR : bresp;
        end
        default: ;
      endcase
    end
  end

`ifdef MESH_AXI_WR_STATS_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stat_done <= 16'h0000;
      stat_err  <= 16'h0000;
    end else if (m_axis_tvalid && m_axis_tready) begin
      if (stat_done != 16'hFFFF) stat_done <= stat_done + 16'd1;
      if (bresp_q != BRESP_OKAY && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mesh_axi_wr_endpoint.sv
// tb/tb_mesh_axi_wr_endpoint.sv - directed self-checking bench for mesh_axi_wr_endpoint
module tb_mesh_axi_wr_endpoint;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [39:0] s_axis_tdata = 40'h0;
  logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
  logic [39:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic [15:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b1;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid;
  logic        wready = 1'b1;
  logic [3:0]  bid = 4'h0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;

  always #5 ACLK = ~ACLK;

  mesh_axi_wr_endpoint #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_WIDTH(4), .ROUTER_X(0), .ROUTER_Y(0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] hdr(input logic [1:0] t, input logic [3:0] sx, input logic [3:0] sy,
                                      input logic [3:0] id, input logic [7:0] len);
    return {t, 8'h00, sx, sy, id, len, 10'h000};
  endfunction

  function automatic logic [39:0] rsp(input logic [3:0] x, input logic [3:0] y, input logic [3:0] id, input logic [1:0] br);
    return {2'b11, x, y, 8'h00, id, 16'h0000, br};
  endfunction

  function automatic logic [39:0] dat(input logic [3:0] strb, input logic [31:0] d);
    return {4'h0, strb, d};
  endfunction

  // bus monitor: handshakes are seen at the falling edge and complete at the next rising edge
  int          cyc = 0;
  logic [31:0] wd_a [64];
  logic [3:0]  ws_a [64];
  logic        wl_a [64];
  int          w_n = 0, aw_n = 0, rsp_n = 0, b_cyc = 0, r_cyc = 0, stable_viol = 0, rsp_wait = 0;
  logic [15:0] aw_addr_l = 16'h0;
  logic [7:0]  aw_len_l = 8'h0;
  logic [3:0]  aw_id_l = 4'h0;
  logic [39:0] rsp_l = 40'h0, pd = 40'h0;
  logic        pv = 1'b0, w_last_hs = 1'b0, b_hs = 1'b0;

  always @(posedge ACLK) cyc++;

  always @(negedge ACLK) begin
    if (awvalid && awready) begin
      aw_n++; aw_addr_l = awaddr; aw_len_l = awlen; aw_id_l = awid;
    end
    if (wvalid && wready) begin
      if (w_n < 64) begin wd_a[w_n] = wdata; ws_a[w_n] = wstrb; wl_a[w_n] = wlast; end
      w_n++;
    end
    w_last_hs = wvalid && wready && wlast;
    b_hs      = bvalid && bready;
    if (b_hs) b_cyc = cyc;
    if (m_axis_tvalid) begin
      if (!pv) r_cyc = cyc;
      else if (m_axis_tdata !== pd) stable_viol++;
      if (m_axis_tlast !== 1'b1) stable_viol++;
      if (!m_axis_tready) rsp_wait++;
    end
    if (m_axis_tvalid && m_axis_tready) begin rsp_n++; rsp_l = m_axis_tdata; end
    pv = m_axis_tvalid && !m_axis_tready;
    pd = m_axis_tdata;
  end

  // AXI slave and response sink
  logic       wr_toggle = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;
  int         hold_cfg = 0, hold_n = 0;

  always @(posedge ACLK) begin
    #1;
    wready = wr_toggle ? !wready : 1'b1;
    if (!ARESETn) bvalid = 1'b0;
    else if (w_last_hs) begin bvalid = 1'b1; bresp = bresp_cfg; end
    else if (b_hs) bvalid = 1'b0;
    if (!m_axis_tvalid) begin hold_n = hold_cfg; m_axis_tready = 1'b1; end
    else if (hold_n > 0) begin hold_n--; m_axis_tready = 1'b0; end
    else m_axis_tready = 1'b1;
  end

  task automatic send(input logic [39:0] f, input logic l);
    logic acc;
    acc = 1'b0;
    s_axis_tdata = f; s_axis_tvalid = 1'b1; s_axis_tlast = l;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge ACLK);
      acc = s_axis_tready;
    end
    chk("flit_accepted", 40'(acc), 40'h1);
    @(posedge ACLK); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 300 && rsp_n < target; i++) @(negedge ACLK);
    @(posedge ACLK); #1;
  endtask

  int wb, ab, rb, rw, sv;

  task automatic snap;
    wb = w_n; ab = aw_n; rb = rsp_n; rw = rsp_wait; sv = stable_viol;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_ctrl", 40'({s_axis_tready, awvalid, wvalid, wlast, bready, m_axis_tvalid}), 40'h0);
    chk("reset_regs", 40'({awaddr, awlen, awid}), 40'h0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // nominal burst
    snap();
    send(hdr(2'b01, 4'd2, 4'd1, 4'd5, 8'd3), 1'b0);
    send(40'h0000000040, 1'b0);
    chk("t1_awvalid_latency", 40'(awvalid), 40'h1);
    for (int i = 0; i < 4; i++) send(dat(4'hF, 32'hA0000000 + 32'(i)), i == 3);
    wait_rsp(rb + 1);
    chk("t1_aw_count", 40'(aw_n - ab), 40'd1);
    chk("t1_aw_fields", 40'({aw_addr_l, aw_len_l, aw_id_l}), 40'({16'h0040, 8'd3, 4'd5}));
    chk("t1_w_count", 40'(w_n - wb), 40'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_w%0d", i), 40'({wl_a[wb+i], ws_a[wb+i], wd_a[wb+i]}), 40'({i == 3, 4'hF, 32'hA0000000 + 32'(i)}));
    chk("t1_rsp_count", 40'(rsp_n - rb), 40'd1);
    chk("t1_rsp_flit", rsp_l, 40'hC840140000);
    chk("t1_rsp_latency", 40'(r_cyc - b_cyc), 40'd1);

    // backpressure on W and on the response port
    wr_toggle = 1'b1; hold_cfg = 5;
    snap();
    send(hdr(2'b01, 4'd3, 4'd2, 4'd9, 8'd3), 1'b0);
    send(40'h0000001234, 1'b0);
    for (int i = 0; i < 4; i++) send(dat(4'(i + 1), 32'hB0000000 + 32'(i)), i == 3);
    wait_rsp(rb + 1);
    chk("t2_w_count", 40'(w_n - wb), 40'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_w%0d", i), 40'({wl_a[wb+i], ws_a[wb+i], wd_a[wb+i]}), 40'({i == 3, 4'(i + 1), 32'hB0000000 + 32'(i)}));
    chk("t2_awaddr", 40'(aw_addr_l), 40'h1234);
    chk("t2_rsp_flit", rsp_l, rsp(4'd3, 4'd2, 4'd9, 2'b00));
    chk("t2_rsp_wait_cycles", 40'(rsp_wait - rw), 40'd5);
    chk("t2_rsp_stable", 40'(stable_viol - sv), 40'd0);
    wr_toggle = 1'b0; hold_cfg = 0;

    // early tlast: two flits for a four-beat burst
    snap();
    send(hdr(2'b01, 4'd1, 4'd1, 4'd6, 8'd3), 1'b0);
    send(40'h0000000080, 1'b0);
    send(dat(4'hF, 32'hC0000000), 1'b0);
    send(dat(4'hF, 32'hC0000001), 1'b1);
    wait_rsp(rb + 1);
    chk("t3_w_count", 40'(w_n - wb), 40'd4);
    chk("t3_w1", 40'({wl_a[wb+1], ws_a[wb+1], wd_a[wb+1]}), 40'({1'b0, 4'hF, 32'hC0000001}));
    chk("t3_w2_pad", 40'({wl_a[wb+2], ws_a[wb+2]}), 40'({1'b0, 4'h0}));
    chk("t3_w3_pad", 40'({wl_a[wb+3], ws_a[wb+3]}), 40'({1'b1, 4'h0}));
    chk("t3_rsp_flit", rsp_l, rsp(4'd1, 4'd1, 4'd6, 2'b10));

    // late tlast: three flits for a two-beat burst
    snap();
    send(hdr(2'b01, 4'd2, 4'd3, 4'd7, 8'd1), 1'b0);
    send(40'h0000000100, 1'b0);
    for (int i = 0; i < 3; i++) send(dat(4'hF, 32'hD0000000 + 32'(i)), i == 2);
    wait_rsp(rb + 1);
    chk("t4_w_count", 40'(w_n - wb), 40'd2);
    chk("t4_wlast", 40'({wl_a[wb], wl_a[wb+1]}), 40'b01);
    chk("t4_w1_data", 40'(wd_a[wb+1]), 40'hD0000001);
    chk("t4_rsp_flit", rsp_l, rsp(4'd2, 4'd3, 4'd7, 2'b10));

    // bad type packet is swallowed, next packet passes an EXOKAY through
    snap();
    send(hdr(2'b11, 4'd4, 4'd4, 4'd1, 8'd0), 1'b0);
    send(40'h0000000200, 1'b0);
    send(dat(4'hF, 32'h12345678), 1'b1);
    repeat (10) @(posedge ACLK);
    #1;
    chk("t5_bad_no_aw", 40'(aw_n - ab), 40'd0);
    chk("t5_bad_no_w", 40'(w_n - wb), 40'd0);
    chk("t5_bad_no_rsp", 40'(rsp_n - rb), 40'd0);
    bresp_cfg = 2'b01;
    send(hdr(2'b01, 4'd1, 4'd3, 4'd3, 8'd0), 1'b0);
    send(40'h0000000002, 1'b0);
    send(dat(4'h5, 32'hE0000000), 1'b1);
    wait_rsp(rb + 1);
    chk("t5_good_w0", 40'({wl_a[wb], ws_a[wb], wd_a[wb]}), 40'({1'b1, 4'h5, 32'hE0000000}));
    chk("t5_good_rsp_flit", rsp_l, rsp(4'd1, 4'd3, 4'd3, 2'b01));

    // early tlast with a DECERR slave keeps DECERR
    bresp_cfg = 2'b11;
    snap();
    send(hdr(2'b01, 4'd4, 4'd4, 4'd10, 8'd1), 1'b0);
    send(40'h0000000300, 1'b0);
    send(dat(4'hF, 32'hF0000000), 1'b1);
    wait_rsp(rb + 1);
    chk("t6_w_count", 40'(w_n - wb), 40'd2);
    chk("t6_rsp_flit", rsp_l, rsp(4'd4, 4'd4, 4'd10, 2'b11));
    bresp_cfg = 2'b00;

    // packet ending on the address flit
    snap();
    send(hdr(2'b01, 4'd5, 4'd6, 4'd11, 8'd2), 1'b0);
    send(40'h0000000400, 1'b1);
    wait_rsp(rb + 1);
    chk("t7_no_aw", 40'(aw_n - ab), 40'd0);
    chk("t7_rsp_flit", rsp_l, rsp(4'd5, 4'd6, 4'd11, 2'b10));

    // reset during the second data beat
    snap();
    send(hdr(2'b01, 4'd1, 4'd2, 4'd12, 8'd3), 1'b0);
    send(40'h0000000500, 1'b0);
    send(dat(4'hF, 32'h11110000), 1'b0);
    s_axis_tdata = dat(4'hF, 32'h11110001); s_axis_tvalid = 1'b1;
    #2 ARESETn = 1'b0;
    #1;
    chk("t8_reset_ctrl", 40'({s_axis_tready, awvalid, wvalid, wlast, bready, m_axis_tvalid}), 40'h0);
    chk("t8_reset_data", 40'({wdata, wstrb}), 40'h0);
    chk("t8_reset_aw", 40'({awaddr, awlen}), 40'h0);
    s_axis_tvalid = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    snap();
    send(hdr(2'b01, 4'd3, 4'd3, 4'd13, 8'd1), 1'b0);
    send(40'h0000000044, 1'b0);
    send(dat(4'hF, 32'h22220000), 1'b0);
    send(dat(4'hF, 32'h22220001), 1'b1);
    wait_rsp(rb + 1);
    chk("t8_after_aw", 40'({aw_addr_l, aw_len_l}), 40'({16'h0044, 8'd1}));
    chk("t8_after_w", 40'({wl_a[wb+1], wd_a[wb+1], wl_a[wb]}), 40'({1'b1, 32'h22220001, 1'b0}));
    chk("t8_after_rsp_count", 40'(rsp_n - rb), 40'd1);
    chk("t8_after_rsp_flit", rsp_l, rsp(4'd3, 4'd3, 4'd13, 2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
